// File: rtl/rv_wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package rv_wb_pkg;

    localparam int WB_DATA_W      = 64;
    localparam int WB_ADDR_W      = 5;
    localparam int CONFLICT_CNT_W = 16;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(input logic [CONFLICT_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer moves to the loser only on a contested grant.
import rv_wb_pkg::*;

module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    wb_src_e rr;

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr == WB_SRC_MEM) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr <= WB_SRC_ALU;
        else if (en && req == 2'b11)
            rr <= (rr == WB_SRC_ALU) ? WB_SRC_MEM : WB_SRC_ALU;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback through a one-entry pending register.
// Optional macro RV_WB_X0_FILTER_EN: accepted writes to x0 complete the handshake but issue no write.
import rv_wb_pkg::*;

module regfile_wb_arbiter #(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ADDR_W-1:0]         a_rd,
    input  logic [DATA_W-1:0]         a_data,
    input  logic                      m_valid,
    output logic                      m_ready,
    input  logic [ADDR_W-1:0]         m_rd,
    input  logic [DATA_W-1:0]         m_data,
    input  logic                      wb_stall,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         rd,
    output logic [DATA_W-1:0]         writeData,
    output logic [CONFLICT_CNT_W-1:0] conflict_count
);

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_rd;
    logic [DATA_W-1:0] pend_data;

    logic              can_accept;
    logic [1:0]        gnt;
    logic              grant;
    wb_src_e           sel;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              x0_drop;

    assign can_accept = !pend_valid || !wb_stall;

    // Reset gates the enable so neither source sees ready while reset is held.
    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({m_valid, a_valid}),
        .en    (can_accept && !reset),
        .gnt   (gnt)
    );

    assign a_ready  = gnt[0];
    assign m_ready  = gnt[1];
    assign grant    = |gnt;
    assign sel      = gnt[1] ? WB_SRC_MEM : WB_SRC_ALU;
    assign sel_rd   = (sel == WB_SRC_MEM) ? m_rd   : a_rd;
    assign sel_data = (sel == WB_SRC_MEM) ? m_data : a_data;

`ifdef RV_WB_X0_FILTER_EN
    assign x0_drop = (sel_rd == '0);
`else
    assign x0_drop = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_rd    <= '0;
            pend_data  <= '0;
        end else if (grant) begin
            pend_valid <= !x0_drop;
            pend_rd    <= sel_rd;
            pend_data  <= sel_data;
        end else if (can_accept) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            conflict_count <= '0;
        else if (a_valid && m_valid && can_accept)
            conflict_count <= sat_inc(conflict_count);
    end

    assign RegWrite  = pend_valid && !wb_stall;
    assign rd        = pend_rd;
    assign writeData = pend_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: stimulus queues expected writes, a negedge monitor retires them as RegWrite fires.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid, m_valid, wb_stall;
    logic        a_ready, m_ready, RegWrite;
    logic [4:0]  a_rd, m_rd, rd;
    logic [63:0] a_data, m_data, writeData;
    logic [15:0] conflict_count;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    localparam logic [63:0] A1 = 64'hA1A1_0000_0000_00A1;
    localparam logic [63:0] M2 = 64'h0000_B2B2_0000_00B2;

    regfile_wb_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_rd           (a_rd),
        .a_data         (a_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_rd           (m_rd),
        .m_data         (m_data),
        .wb_stall       (wb_stall),
        .RegWrite       (RegWrite),
        .rd             (rd),
        .writeData      (writeData),
        .conflict_count (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push(input logic [4:0] r, input logic [63:0] d);
        wb_exp_t e;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && RegWrite) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL wb_unexpected: got write rd=%0d data=%0h, required no write", rd, writeData);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                check("wb_rd", 64'(rd), 64'(e.rd));
                check("wb_data", writeData, e.data);
            end
        end
    end

    initial begin
        logic exp_alu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; wb_stall = 1'b0;
        a_valid = 1'b1; m_valid = 1'b1;
        a_rd = 5'd3; m_rd = 5'd4; a_data = 64'h1; m_data = 64'h2;
        @(negedge clk);
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_a_ready", 64'(a_ready), 64'd0);
        check("rst_m_ready", 64'(m_ready), 64'd0);
        check("rst_count", 64'(conflict_count), 64'd0);
        next_cycle();
        reset = 1'b0; a_valid = 1'b0; m_valid = 1'b0;

        // single ALU request
        next_cycle();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h1234;
        @(negedge clk);
        check("single_a_ready", 64'(a_ready), 64'd1);
        check("single_m_ready", 64'(m_ready), 64'd0);
        push(5'd5, 64'h1234);
        next_cycle();
        a_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("idle_regwrite", 64'(RegWrite), 64'd0);

        // sustained conflict alternates ALU, MEM, ALU, MEM
        next_cycle();
        a_valid = 1'b1; m_valid = 1'b1; a_rd = 5'd1; m_rd = 5'd2; a_data = A1; m_data = M2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_a_ready", 64'(a_ready), 64'(exp_alu[i]));
            check("rr_m_ready", 64'(m_ready), 64'(!exp_alu[i]));
            if (exp_alu[i]) push(5'd1, A1);
            else            push(5'd2, M2);
            next_cycle();
        end
        a_valid = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        check("rr_count", 64'(conflict_count), 64'd4);

        // stall holds the pending MEM entry and blocks the ALU
        next_cycle();
        m_valid = 1'b1; m_rd = 5'd7; m_data = 64'h77;
        @(negedge clk);
        check("stall_m_ready", 64'(m_ready), 64'd1);
        push(5'd7, 64'h77);
        next_cycle();
        m_valid = 1'b0; a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h33; wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_regwrite", 64'(RegWrite), 64'd0);
            check("stall_rd_hold", 64'(rd), 64'd7);
            check("stall_a_ready", 64'(a_ready), 64'd0);
            next_cycle();
        end
        wb_stall = 1'b0;
        @(negedge clk);
        check("unstall_regwrite", 64'(RegWrite), 64'd1);
        check("unstall_a_ready", 64'(a_ready), 64'd1);
        push(5'd3, 64'h33);
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk);
        check("stall_count", 64'(conflict_count), 64'd4);

        // asynchronous reset while an entry is pending
        next_cycle();
        a_valid = 1'b1; m_valid = 1'b1; a_rd = 5'd9; m_rd = 5'd10; a_data = 64'h99; m_data = 64'hAA;
        @(negedge clk);
        check("mid_a_ready", 64'(a_ready), 64'd1);
        next_cycle();
        a_valid = 1'b0; wb_stall = 1'b1;
        @(negedge clk);
        check("mid_stall_regwrite", 64'(RegWrite), 64'd0);
        check("mid_stall_rd", 64'(rd), 64'd9);
        check("mid_stall_m_ready", 64'(m_ready), 64'd0);
        next_cycle();
        wb_stall = 1'b0;
        #1;
        check("pre_reset_regwrite", 64'(RegWrite), 64'd1);
        check("pre_reset_count", 64'(conflict_count), 64'd5);
        reset = 1'b1; a_valid = 1'b1;
        #1;
        check("async_regwrite", 64'(RegWrite), 64'd0);
        check("async_a_ready", 64'(a_ready), 64'd0);
        check("async_m_ready", 64'(m_ready), 64'd0);
        check("async_count", 64'(conflict_count), 64'd0);
        next_cycle();
        reset = 1'b0; a_rd = 5'd4; m_rd = 5'd6; a_data = 64'h44; m_data = 64'h66;
        @(negedge clk);
        check("post_rst_a_ready", 64'(a_ready), 64'd1);
        push(5'd4, 64'h44);
        next_cycle();
        @(negedge clk);
        check("post_rst_m_ready", 64'(m_ready), 64'd1);
        check("post_rst_count1", 64'(conflict_count), 64'd1);
        push(5'd6, 64'h66);
        next_cycle();
        a_valid = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        check("post_rst_count2", 64'(conflict_count), 64'd2);

        // write to x0
        next_cycle();
        a_valid = 1'b1; a_rd = 5'd0; a_data = 64'hFF;
        @(negedge clk);
        check("x0_a_ready", 64'(a_ready), 64'd1);
`ifndef RV_WB_X0_FILTER_EN
        push(5'd0, 64'hFF);
`endif
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk);
`ifdef RV_WB_X0_FILTER_EN
        check("x0_regwrite", 64'(RegWrite), 64'd0);
`else
        check("x0_regwrite", 64'(RegWrite), 64'd1);
`endif

        // counter saturation
        next_cycle();
        a_valid = 1'b1; m_valid = 1'b1; a_rd = 5'd1; m_rd = 5'd2; a_data = A1; m_data = M2;
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            if (i % 2 == 0) push(5'd1, A1);
            else            push(5'd2, M2);
            next_cycle();
        end
        a_valid = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        check("sat_count", 64'(conflict_count), 64'hFFFF);
        next_cycle();
        a_valid = 1'b1; m_valid = 1'b1;
        @(negedge clk);
        check("sat_a_ready", 64'(a_ready), 64'd1);
        push(5'd1, A1);
        next_cycle();
        a_valid = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        check("sat_hold", 64'(conflict_count), 64'hFFFF);

        repeat (3) next_cycle();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
